// File: rtl/fwd_hazard_unit_if.sv
// Issue-side bundle for the forwarding/hazard unit.
//   master : issue stage (drives issue fields, flush, fwd_enable; sees results)
//   slave  : fwd_hazard_unit
// Ports: issue_valid, issue_reg_write, issue_is_load, issue_dest, issue_src,
//        issue_src_used, flush, fwd_enable -> unit; fwd_sel, stall, stall_count <- unit.
interface fwd_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 3,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) ();
  logic                          issue_valid;
  logic                          issue_reg_write;
  logic                          issue_is_load;
  logic [REG_ADDR_W-1:0]         issue_dest;
  logic [NUM_SRC*REG_ADDR_W-1:0] issue_src;
  logic [NUM_SRC-1:0]            issue_src_used;
  logic                          flush;
  logic                          fwd_enable;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic                          stall;
  logic [15:0]                   stall_count;

  modport master (
    output issue_valid, issue_reg_write, issue_is_load, issue_dest,
           issue_src, issue_src_used, flush, fwd_enable,
    input  fwd_sel, stall, stall_count
  );

  modport slave (
    input  issue_valid, issue_reg_write, issue_is_load, issue_dest,
           issue_src, issue_src_used, flush, fwd_enable,
    output fwd_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard-detection unit for the pipelined MIPS core.
// Tracks DEPTH in-flight destination tags (stage 1 = youngest) and, for each of
// NUM_SRC source operands, selects the register file (0) or the youngest
// matching stage k. Load-use and interlock stalls are generated here.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fwd_hazard_unit_if.slave (issue fields in; fwd_sel, stall,
//                stall_count out)
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  fwd_hazard_unit_if.slave bus
);

  logic [DEPTH:1]        st_valid;
  logic [DEPTH:1]        st_rw;
  logic [DEPTH:1]        st_load;
  logic [REG_ADDR_W-1:0] st_dest [1:DEPTH];

  logic [DEPTH:1]        match [NUM_SRC];
  logic [SEL_W-1:0]      ysel  [NUM_SRC];
  logic [NUM_SRC-1:0]    yload;
  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic                  not_ready;
  logic                  stall;
  logic [15:0]           stall_cnt;

  always_comb begin
    match = '{default: '0};
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 1; k <= DEPTH; k++) begin
        match[i][k] = st_valid[k] & st_rw[k] & bus.issue_src_used[i]
                    & (st_dest[k] == bus.issue_src[i*REG_ADDR_W +: REG_ADDR_W])
                    & (bus.issue_src[i*REG_ADDR_W +: REG_ADDR_W] != '0);
      end
    end
  end

  always_comb begin
    ysel      = '{default: '0};
    yload     = '0;
    sel_raw   = '0;
    not_ready = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // Scan oldest to youngest so the youngest producer overwrites.
      for (int k = DEPTH; k >= 1; k--) begin
        if (match[i][k]) begin
          ysel[i]  = SEL_W'(k);
          yload[i] = st_load[k];
        end
      end
      if (bus.fwd_enable) begin
        if (ysel[i] != '0) begin
          if (yload[i] && (int'(ysel[i]) < LOAD_LAT))
            not_ready = 1'b1;
          else
            sel_raw[i*SEL_W +: SEL_W] = ysel[i];
        end
      end else begin
        // Stage DEPTH is being written back; the write-through regfile covers it.
        for (int k = 1; k < DEPTH; k++) begin
          if (match[i][k]) not_ready = 1'b1;
        end
      end
    end
  end

  assign stall           = bus.issue_valid & ~bus.flush & not_ready;
  assign bus.stall       = stall;
  assign bus.fwd_sel     = stall ? '0 : sel_raw;
  assign bus.stall_count = stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid  <= '0;
      st_rw     <= '0;
      st_load   <= '0;
      for (int k = 1; k <= DEPTH; k++) st_dest[k] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        st_valid[k] <= st_valid[k-1];
        st_rw[k]    <= st_rw[k-1];
        st_load[k]  <= st_load[k-1];
        st_dest[k]  <= st_dest[k-1];
      end
      st_valid[1] <= bus.issue_valid & ~stall & ~bus.flush;
      st_rw[1]    <= bus.issue_reg_write;
      st_load[1]  <= bus.issue_is_load;
      st_dest[1]  <= bus.issue_dest;
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  fwd_hazard_unit_if bus ();

  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(3), .DEPTH(3), .LOAD_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic drive(input logic v, input logic rw, input logic ld,
                       input logic [4:0] d, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] used, input logic fl);
    bus.issue_valid     = v;
    bus.issue_reg_write = rw;
    bus.issue_is_load   = ld;
    bus.issue_dest      = d;
    bus.issue_src       = {s2, s1, s0};
    bus.issue_src_used  = used;
    bus.flush           = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    bus.fwd_enable = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b0) begin failed++; $display("FAIL reset_stall: got %0b want 0", bus.stall); end
    tests++; if (bus.fwd_sel !== 6'd0) begin failed++; $display("FAIL reset_sel: got %b want 000000", bus.fwd_sel); end
    tests++; if (bus.stall_count !== 16'd0) begin failed++; $display("FAIL reset_count: got %0d want 0", bus.stall_count); end
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    step();
  endtask

  task automatic test_fwd_ex();
    logic [5:0] exp_sel [4];
    exp_sel[0] = 6'b000001; exp_sel[1] = 6'b000010;
    exp_sel[2] = 6'b000011; exp_sel[3] = 6'b000000;
    idle();
    drive(1, 1, 0, 5'd3, 0, 0, 0, 3'b000, 0);
    step();
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 0, 5'd9, 5'd3, 0, 0, 3'b001, 0);
      @(negedge clk);
      tests++; if (bus.fwd_sel !== exp_sel[c] || bus.stall !== 1'b0) begin
        failed++; $display("FAIL fwd_ex_%0d: sel=%b stall=%0b want sel=%b stall=0", c, bus.fwd_sel, bus.stall, exp_sel[c]);
      end
      step();
    end
  endtask

  task automatic test_multi_src();
    idle();
    drive(1, 1, 0, 5'd7, 0, 0, 0, 3'b000, 0); step();
    drive(1, 1, 0, 5'd8, 0, 0, 0, 3'b000, 0); step();
    drive(1, 0, 0, 5'd0, 5'd7, 5'd8, 5'd7, 3'b111, 0);
    @(negedge clk);
    tests++; if (bus.fwd_sel !== 6'b100110 || bus.stall !== 1'b0) begin
      failed++; $display("FAIL multi_src: sel=%b stall=%0b want sel=100110 stall=0", bus.fwd_sel, bus.stall);
    end
    step();
    drive(1, 0, 0, 5'd0, 5'd7, 5'd8, 5'd7, 3'b011, 0);
    @(negedge clk);
    tests++; if (bus.fwd_sel !== 6'b001011) begin
      failed++; $display("FAIL unused_src: sel=%b want 001011", bus.fwd_sel);
    end
    step();
  endtask

  task automatic test_youngest();
    idle();
    drive(1, 1, 0, 5'd4, 0, 0, 0, 3'b000, 0); step();
    drive(1, 1, 0, 5'd4, 0, 0, 0, 3'b000, 0); step();
    drive(1, 0, 0, 5'd0, 5'd4, 0, 0, 3'b001, 0);
    @(negedge clk);
    tests++; if (bus.fwd_sel !== 6'b000001) begin
      failed++; $display("FAIL youngest: sel=%b want 000001", bus.fwd_sel);
    end
    step();
    idle();
    drive(1, 1, 1, 5'd0, 0, 0, 0, 3'b000, 0); step();
    drive(1, 0, 0, 5'd0, 5'd0, 0, 0, 3'b001, 0);
    @(negedge clk);
    tests++; if (bus.fwd_sel !== 6'b000000 || bus.stall !== 1'b0) begin
      failed++; $display("FAIL r0_filter: sel=%b stall=%0b want sel=000000 stall=0", bus.fwd_sel, bus.stall);
    end
    step();
  endtask

  task automatic test_load_use();
    idle();
    drive(1, 1, 1, 5'd5, 0, 0, 0, 3'b000, 0); step();
    drive(1, 0, 0, 5'd0, 0, 5'd5, 0, 3'b010, 0);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b1 || bus.fwd_sel !== 6'd0) begin
      failed++; $display("FAIL load_use_stall: stall=%0b sel=%b want stall=1 sel=000000", bus.stall, bus.fwd_sel);
    end
    step();
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    tests++; if (bus.stall !== 1'b0 || bus.fwd_sel !== 6'b001000) begin
      failed++; $display("FAIL load_use_fwd: stall=%0b sel=%b want stall=0 sel=001000", bus.stall, bus.fwd_sel);
    end
    tests++; if (bus.stall_count !== exp_cnt) begin
      failed++; $display("FAIL load_use_count: got %0d want %0d", bus.stall_count, exp_cnt);
    end
    step();
  endtask

  task automatic test_interlock();
    bus.fwd_enable = 1'b0;
    idle();
    drive(1, 1, 0, 5'd3, 0, 0, 0, 3'b000, 0); step();
    drive(1, 0, 0, 5'd0, 5'd3, 0, 0, 3'b001, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++; if (bus.stall !== 1'b1) begin
        failed++; $display("FAIL interlock_stall_%0d: stall=%0b want 1", c, bus.stall);
      end
      step();
      exp_cnt = exp_cnt + 16'd1;
    end
    @(negedge clk);
    tests++; if (bus.stall !== 1'b0 || bus.fwd_sel !== 6'd0) begin
      failed++; $display("FAIL interlock_release: stall=%0b sel=%b want stall=0 sel=000000", bus.stall, bus.fwd_sel);
    end
    tests++; if (bus.stall_count !== exp_cnt) begin
      failed++; $display("FAIL interlock_count: got %0d want %0d", bus.stall_count, exp_cnt);
    end
    step();
    bus.fwd_enable = 1'b1;
  endtask

  task automatic test_flush();
    idle();
    drive(1, 1, 1, 5'd5, 0, 0, 0, 3'b000, 0); step();
    drive(1, 1, 1, 5'd9, 0, 5'd5, 0, 3'b010, 1);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b0) begin
      failed++; $display("FAIL flush_stall: stall=%0b want 0", bus.stall);
    end
    step();
    drive(1, 0, 0, 5'd0, 5'd9, 5'd5, 0, 3'b011, 0);
    @(negedge clk);
    tests++; if (bus.fwd_sel !== 6'b001000 || bus.stall !== 1'b0) begin
      failed++; $display("FAIL flush_bubble: sel=%b stall=%0b want sel=001000 stall=0", bus.fwd_sel, bus.stall);
    end
    tests++; if (bus.stall_count !== exp_cnt) begin
      failed++; $display("FAIL flush_count: got %0d want %0d", bus.stall_count, exp_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    idle();
    drive(1, 1, 1, 5'd5, 0, 0, 0, 3'b000, 0); step();
    drive(1, 0, 0, 5'd0, 0, 5'd5, 0, 3'b010, 0);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b1) begin
      failed++; $display("FAIL mid_stall_pre: stall=%0b want 1", bus.stall);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.stall !== 1'b0 || bus.stall_count !== 16'd0) begin
      failed++; $display("FAIL async_reset: stall=%0b count=%0d want stall=0 count=0", bus.stall, bus.stall_count);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (bus.fwd_sel !== 6'd0 || bus.stall !== 1'b0) begin
      failed++; $display("FAIL post_reset_sel: sel=%b stall=%0b want sel=000000 stall=0", bus.fwd_sel, bus.stall);
    end
    step();
    @(negedge clk);
    tests++; if (bus.stall_count !== 16'd0) begin
      failed++; $display("FAIL post_reset_count: got %0d want 0", bus.stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_multi_src();
    test_youngest();
    test_load_use();
    test_interlock();
    test_flush();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard-detection unit for the pipelined MIPS core. It sits alongside the ID/EX boundary and keeps its own shift pipeline of in-flight destination tags, DEPTH stages deep. For each of NUM_SRC source operands it selects between the register file and the youngest matching in-flight stage. It generates load-use and interlock stalls itself, so no external stall logic is needed.

## Interface
- REG_ADDR_W, 5: register-address width; register 0 is hard-wired zero.
- NUM_SRC, 3: source operands checked per issue (rs, rt, store-data).
- DEPTH, 3: in-flight stages tracked (1 = EX, 2 = MEM, 3 = WB).
- LOAD_LAT, 2: lowest stage index at which a load result can be forwarded; 1 ≤ LOAD_LAT ≤ DEPTH.
- SEL_W, $clog2(DEPTH+1): width of each forward-select field (derived).
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- IssueValid  in  1  an instruction is presented for issue.
- IssueRegWrite  in  1  the issuing instruction writes IssueDest.
- IssueIsLoad  in  1  the issuing instruction is a load (lw/lh/lb).
- IssueDest  in  REG_ADDR_W  destination register of the issuing instruction.
- IssueSrc  in  NUM_SRC*REG_ADDR_W  source registers; field i is bits [i*REG_ADDR_W +: REG_ADDR_W].
- IssueSrcUsed  in  NUM_SRC  bit i set when source i is actually read.
- Flush  in  1  kill the issuing instruction (branch/jump redirect).
- FwdEnable  in  1  1 = forwarding mode, 0 = full-interlock mode.
- FwdSel  out  NUM_SRC*SEL_W  per-source select: 0 = register file, k = stage k result.
- Stall  out  1  hold the issuing instruction this cycle.
- StallCount  out  16  saturating count of stall cycles.

## Operation
- State per stage k (1..DEPTH): Valid, Dest, RegWrite, IsLoad. Stage 1 is the youngest.
- Every edge: stage k+1 ← stage k. Stage 1 ← issue fields if IssueValid & !Stall & !Flush; otherwise stage 1 takes a bubble (Valid = 0).
- Match(i, k): Valid[k] & RegWrite[k] & Dest[k] == Src_i & Src_i != 0 & IssueSrcUsed[i].
- Forwarding mode: for each source, k* = the smallest k with Match(i, k).
  - If stage k* is a load and k* < LOAD_LAT, the source is not ready.
  - Otherwise FwdSel_i = k*.
  - With no match, FwdSel_i = 0.
  - Older matches are always ignored: the youngest producer wins.
- Interlock mode (FwdEnable = 0): any Match(i, k) with k < DEPTH makes the source not ready. A match only at stage DEPTH gives FwdSel_i = 0 (register file is write-through).
- Stall = IssueValid & !Flush & (any source not ready).
- When Stall = 1, every FwdSel field is driven 0.
- The stalled instruction is re-presented by upstream and re-evaluated each cycle.
- StallCount increments on every edge where Stall = 1 and holds at 16'hFFFF.
- Flush has priority over Stall: the killed instruction never enters the pipe, and Stall = 0 that cycle.
- FwdEnable may change on any cycle and takes effect combinationally.

## Timing
- Stall and FwdSel are combinational from the issue inputs and registered stage state, valid in the same cycle; no added latency.
- Producer-to-consumer spacing in forwarding mode:
  - ALU producer issued at cycle t: a consumer at t+1 gets select 1, at t+2 select 2.
  - Load producer with LOAD_LAT = 2: a consumer at t+1 stalls 1 cycle, then gets select 2.
- Interlock mode: a consumer directly behind its producer stalls DEPTH−1 cycles.
- Reset (Rst_n low, any time, including mid-stall): all Valid cleared and StallCount = 0 immediately. Outputs are then FwdSel = 0, Stall = 0 while the issue inputs present no hazard.
- The first edge after reset release shifts normally.

## Test plan
- Forward from EX: issue add r3 (RegWrite=1), next cycle src0=r3 used -> FwdSel[0]=1, Stall=0. One cycle later (after a bubble) -> FwdSel[0]=2.
- Load-use: issue lw r5, next cycle src1=r5 -> Stall=1 for exactly 1 cycle, StallCount=1. Re-presented cycle -> FwdSel[1]=2, Stall=0.
- Youngest wins and r0 filter: stage 1 and stage 2 both write r4, src0=r4 -> FwdSel[0]=1. Producer writes r0, src0=r0 -> FwdSel[0]=0.
- Interlock mode: FwdEnable=0, add r3 then src0=r3 -> Stall high 2 cycles. Third cycle -> FwdSel[0]=0, Stall=0, StallCount=2.
- Flush priority: Flush=1 with a load-use hazard present -> Stall=0, stage 1 receives a bubble, and a consumer of that dest next cycle sees no match.
- Reset mid-stall: Rst_n low during a load-use stall -> Stall=0 and StallCount=0 asynchronously. After release, the same sources give FwdSel=0.
